eyeriss_glb_multicast: RTL and testbench

- Upstream feeder for the PE array: takes a tagged word stream from the global buffer and drives the shared map/filter/psum buses, the `id_in` tag bus and the `getdata_fil` / `getdata_map` / `getdata_psum` strobes that every PE compares against its configured id.
- Contains a small input FIFO, a word-budget FSM and array-stall handling.
- One instance drives one PE row bus.

---
 rtl/eyeriss_glb_multicast.sv | 137 +++++++++++++
 tb/tb_eyeriss_glb_multicast.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eyeriss_glb_multicast.sv
// GLB-to-PE-row multicast feeder: buffers tagged GLB words in a small FIFO and
// replays them onto the shared map/filter/psum buses with one-cycle id strobes.
module eyeriss_glb_multicast #(
    parameter int DW    = 16,
    parameter int IDW   = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 12
) (
    input  logic           CLK,
    input  logic           clr,
    input  logic           cfg_start,
    input  logic [CW-1:0]  cfg_total,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    input  logic [1:0]     in_kind,
    input  logic [IDW-1:0] in_id,
    input  logic           stall,
    output logic [DW-1:0]  map,
    output logic [DW-1:0]  filter,
    output logic [DW-1:0]  psum_glb,
    output logic [IDW-1:0] id_out,
    output logic           getdata_fil,
    output logic           getdata_map,
    output logic           getdata_psum,
    output logic           busy,
    output logic           done,
    output logic           err_kind
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    typedef struct packed {
        logic [1:0]     kind;
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } word_t;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          state;
    word_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic [CW-1:0]   budget, acc_cnt, del_cnt;
    logic            full, empty, push, pop, last_del;
    word_t           head;

    assign full     = (count == CNTW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = (state == RUN) && !full && (acc_cnt < budget);
    assign push     = in_valid && in_ready;
    assign pop      = (state == RUN) && !stall && !empty;
    assign head     = mem[rd_ptr];
    // del_cnt < budget whenever a pop happens, so the +1 never overflows CW bits
    assign last_del = ((del_cnt + CW'(1)) == budget);
    assign busy     = (state == RUN);

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= '{kind: in_kind, id: in_id, data: in_data};
    end

    always_ff @(posedge CLK or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            budget       <= '0;
            acc_cnt      <= '0;
            del_cnt      <= '0;
            map          <= '0;
            filter       <= '0;
            psum_glb     <= '0;
            id_out       <= '0;
            getdata_fil  <= 1'b0;
            getdata_map  <= 1'b0;
            getdata_psum <= 1'b0;
            done         <= 1'b0;
            err_kind     <= 1'b0;
        end else begin
            getdata_fil  <= 1'b0;
            getdata_map  <= 1'b0;
            getdata_psum <= 1'b0;
            done         <= 1'b0;

            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                acc_cnt <= acc_cnt + CW'(1);
            end

            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                del_cnt <= del_cnt + CW'(1);
                unique case (head.kind)
                    2'd0: begin filter   <= head.data; id_out <= head.id; getdata_fil  <= 1'b1; end
                    2'd1: begin map      <= head.data; id_out <= head.id; getdata_map  <= 1'b1; end
                    2'd2: begin psum_glb <= head.data; id_out <= head.id; getdata_psum <= 1'b1; end
                    // reserved kind is consumed silently so the budget still completes
                    default: err_kind <= 1'b1;
                endcase
            end

            unique case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase

            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_total == '0) begin
                            done <= 1'b1;
                        end else begin
                            budget  <= cfg_total;
                            acc_cnt <= '0;
                            del_cnt <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pop && last_del) state <= FIN;
                end
                // done becomes visible the cycle after the final strobe
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eyeriss_glb_multicast.sv
// Bench for eyeriss_glb_multicast: directed test-plan scenarios plus randomized
// transfers, all checked against a transaction-queue reference model.
module tb_eyeriss_glb_multicast;

    localparam int DW    = 16;
    localparam int IDW   = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 12;

    logic           CLK = 1'b0;
    logic           clr, cfg_start, in_valid, stall;
    logic [CW-1:0]  cfg_total;
    logic [DW-1:0]  in_data;
    logic [1:0]     in_kind;
    logic [IDW-1:0] in_id;
    logic           in_ready, getdata_fil, getdata_map, getdata_psum, busy, done, err_kind;
    logic [DW-1:0]  map, filter, psum_glb;
    logic [IDW-1:0] id_out;

    eyeriss_glb_multicast #(.DW(DW), .IDW(IDW), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .clr(clr), .cfg_start(cfg_start), .cfg_total(cfg_total),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_kind(in_kind), .in_id(in_id), .stall(stall),
        .map(map), .filter(filter), .psum_glb(psum_glb), .id_out(id_out),
        .getdata_fil(getdata_fil), .getdata_map(getdata_map), .getdata_psum(getdata_psum),
        .busy(busy), .done(done), .err_kind(err_kind)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]     kind;
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
    } ent_t;

    // reference model: words in flight, transfer phase (0 idle, 1 run, 2 closing)
    ent_t           q[$];
    int             mode, budget, acc, del;
    logic [DW-1:0]  m_map, m_fil, m_psum;
    logic [IDW-1:0] m_id;
    logic           m_sf, m_sm, m_sp, m_done, m_err;

    int tests = 0, fails = 0;
    int n_hs, n_strobe, n_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void mreset();
        q.delete();
        mode = 0; budget = 0; acc = 0; del = 0;
        m_map = '0; m_fil = '0; m_psum = '0; m_id = '0;
        m_sf = 0; m_sm = 0; m_sp = 0; m_done = 0; m_err = 0;
    endfunction

    task automatic check_outs();
        chk("map", map, m_map);
        chk("filter", filter, m_fil);
        chk("psum_glb", psum_glb, m_psum);
        chk("id_out", id_out, m_id);
        chk("getdata_fil", getdata_fil, m_sf);
        chk("getdata_map", getdata_map, m_sm);
        chk("getdata_psum", getdata_psum, m_sp);
        chk("done", done, m_done);
        chk("err_kind", err_kind, m_err);
        chk("busy", busy, mode == 1);
    endtask

    // one clock: check in_ready before the edge, advance model, check outputs after
    task automatic step();
        bit   exp_ready, do_pop, do_push;
        ent_t w;
        exp_ready = (mode == 1) && (q.size() < DEPTH) && (acc < budget);
        chk("in_ready", in_ready, exp_ready);
        @(posedge CLK);
        if (!clr) begin
            mreset();
        end else begin
            m_sf = 0; m_sm = 0; m_sp = 0;
            m_done  = (mode == 2) || (mode == 0 && cfg_start && cfg_total == 0);
            do_pop  = (mode == 1) && !stall && (q.size() > 0);
            do_push = in_valid && exp_ready;
            if (do_pop) begin
                w = q.pop_front();
                del++;
                case (w.kind)
                    2'd0: begin m_fil  = w.data; m_id = w.id; m_sf = 1; end
                    2'd1: begin m_map  = w.data; m_id = w.id; m_sm = 1; end
                    2'd2: begin m_psum = w.data; m_id = w.id; m_sp = 1; end
                    default: m_err = 1;
                endcase
            end
            if (do_push) begin
                q.push_back('{in_kind, in_id, in_data});
                acc++;
                n_hs++;
            end
            case (mode)
                0: if (cfg_start && cfg_total != 0) begin
                       mode = 1; budget = int'(cfg_total); acc = 0; del = 0;
                   end
                1: if (do_pop && del == budget) mode = 2;
                default: mode = 0;
            endcase
        end
        #1;
        check_outs();
        n_strobe += int'(getdata_fil) + int'(getdata_map) + int'(getdata_psum);
        n_done   += int'(done);
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [IDW-1:0] id, input logic [DW-1:0] d);
        in_valid = v; in_kind = k; in_id = id; in_data = d;
    endtask

    task automatic start(input int total);
        n_hs = 0; n_strobe = 0; n_done = 0;
        cfg_start = 1; cfg_total = CW'(total);
        step();
        cfg_start = 0;
    endtask

    task automatic run_to_idle(input int bound);
        int n = 0;
        while (mode != 0 && n < bound) begin step(); n++; end
        chk("timeout_idle", mode, 0);
    endtask

    initial begin
        clr = 0; cfg_start = 0; cfg_total = '0; stall = 0;
        drive(0, 0, 0, 0);
        mreset();
        #2;
        check_outs();
        chk("rst_in_ready", in_ready, 0);
        step(); step();
        clr = 1;
        step();

        // basic order: three kinds back to back
        start(3);
        drive(1, 2'd0, 8'd5, 16'h1111); step();
        drive(1, 2'd1, 8'd5, 16'h2222); step();
        drive(1, 2'd2, 8'd7, 16'h3333); step();
        drive(0, 0, 0, 0);
        run_to_idle(20);
        chk("basic_strobes", n_strobe, 3);
        chk("basic_done", n_done, 1);
        chk("basic_filter", filter, 16'h1111);
        chk("basic_map", map, 16'h2222);
        chk("basic_psum", psum_glb, 16'h3333);
        chk("basic_id", id_out, 8'd7);

        // back-pressure: FIFO fills, nothing delivered until stall drops
        stall = 1;
        start(6);
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'(i % 3), 8'(i), 16'(16'h100 + i));
            step();
        end
        chk("bp_accepts", n_hs, 4);
        chk("bp_no_strobe", n_strobe, 0);
        stall = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'(i % 3), 8'(i + 8), 16'(16'h200 + i));
            step();
        end
        drive(0, 0, 0, 0);
        run_to_idle(30);
        chk("bp_total_accepts", n_hs, 6);
        chk("bp_strobes", n_strobe, 6);
        chk("bp_done", n_done, 1);

        // budget cap with in_valid held high
        start(2);
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'd1, 8'(20 + i), 16'(16'h300 + i));
            step();
        end
        drive(0, 0, 0, 0);
        run_to_idle(20);
        chk("cap_accepts", n_hs, 2);
        chk("cap_strobes", n_strobe, 2);
        chk("cap_done", n_done, 1);

        // reserved kind is dropped but counted
        start(2);
        drive(1, 2'd3, 8'd9, 16'hDEAD); step();
        drive(1, 2'd1, 8'd4, 16'hABCD); step();
        drive(0, 0, 0, 0);
        run_to_idle(20);
        chk("rsv_strobes", n_strobe, 1);
        chk("rsv_err", err_kind, 1);
        chk("rsv_map", map, 16'hABCD);
        chk("rsv_done", n_done, 1);

        // zero-length start and a start ignored mid-transfer
        start(0);
        step();
        chk("zero_done", n_done, 1);
        start(3);
        cfg_start = 1; cfg_total = CW'(9);
        drive(1, 2'd2, 8'd1, 16'h0042); step();
        cfg_start = 0;
        for (int i = 0; i < 10; i++) step();
        drive(0, 0, 0, 0);
        run_to_idle(20);
        chk("ign_accepts", n_hs, 3);
        chk("ign_strobes", n_strobe, 3);

        // asynchronous reset mid-transfer with 3 words queued
        stall = 1;
        start(8);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'd0, 8'(30 + i), 16'(16'h400 + i));
            step();
        end
        drive(0, 0, 0, 0);
        n_done = 0;
        #2 clr = 0;
        mreset();
        #1;
        check_outs();
        chk("amid_in_ready", in_ready, 0);
        step(); step();
        clr = 1; stall = 0;
        step();
        chk("amid_no_done", n_done, 0);
        start(2);
        drive(1, 2'd1, 8'd3, 16'h5555); step();
        drive(1, 2'd2, 8'd3, 16'h6666); step();
        drive(0, 0, 0, 0);
        run_to_idle(20);
        chk("post_rst_strobes", n_strobe, 2);
        chk("post_rst_done", n_done, 1);

        // randomized transfers
        for (int t = 0; t < 25; t++) begin
            int total;
            total = int'($urandom_range(1, 12));
            stall = 0;
            start(total);
            for (int n = 0; n < 400 && mode != 0; n++) begin
                drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                      8'($urandom), 16'($urandom));
                stall     = ($urandom_range(0, 9) < 3);
                cfg_start = ($urandom_range(0, 9) == 0);
                cfg_total = CW'($urandom_range(1, 12));
                step();
            end
            cfg_start = 0; stall = 0;
            drive(0, 0, 0, 0);
            chk("rnd_idle", mode, 0);
            chk("rnd_accepts", n_hs, total);
            chk("rnd_done", n_done, 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
